bcd_to_binary: RTL and testbench

//  Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from each BCD nibble >= 8.

---
 rtl/bcd_to_binary_if.sv | 24 ++
 rtl/bcd_to_binary.sv | 95 +++++++++
 tb/tb_bcd_to_binary.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_if.sv
// Start/data-valid handshake bundle shared by the BCD<->binary conversion engines.
// The master drives the operand and start request; the slave returns the result and status flags.
interface bcd_to_binary_if #(
  parameter int DECIMAL_DIGITS = 4,
  parameter int OUTPUT_WIDTH   = 16
);
  logic [4*DECIMAL_DIGITS-1:0] i_bcd;
  logic                        i_start;
  logic [OUTPUT_WIDTH-1:0]     o_binary;
  logic                        o_dv;
  logic                        o_busy;
  logic                        o_error;
  logic                        o_overflow;

  modport master (
    output i_bcd, i_start,
    input  o_binary, o_dv, o_busy, o_error, o_overflow
  );

  modport slave (
    input  i_bcd, i_start,
    output o_binary, o_dv, o_busy, o_error, o_overflow
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one shift per cycle.
// The result and flags are registered and presented with a one-cycle o_dv pulse.
module bcd_to_binary #(
  parameter int DECIMAL_DIGITS = 4,
  parameter int OUTPUT_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  bcd_to_binary_if.slave   bus
);
  localparam int BW = 4 * DECIMAL_DIGITS;
  localparam int SW = BW + OUTPUT_WIDTH;
  localparam int CW = $clog2(OUTPUT_WIDTH + 1);

  typedef enum logic [1:0] {s_IDLE, s_SHIFT, s_DONE} state_t;

  state_t                  state_q;
  logic [SW-1:0]           sr_q, sr_d, shifted;
  logic [CW-1:0]           ctr_q;
  logic                    err_q;
  logic                    digit_bad;
  logic [OUTPUT_WIDTH-1:0] binary_q;
  logic                    dv_q, busy_q, error_q, overflow_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      if (bus.i_bcd[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  always_comb begin
    shifted = sr_q >> 1;
    sr_d    = shifted;
    for (int i = 0; i < DECIMAL_DIGITS; i++) begin
      if (shifted[OUTPUT_WIDTH+4*i +: 4] >= 4'd8)
        sr_d[OUTPUT_WIDTH+4*i +: 4] = shifted[OUTPUT_WIDTH+4*i +: 4] - 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= s_IDLE;
      sr_q       <= '0;
      ctr_q      <= '0;
      err_q      <= 1'b0;
      binary_q   <= '0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      unique case (state_q)
        s_IDLE: begin
          if (bus.i_start) begin
            state_q <= s_SHIFT;
            busy_q  <= 1'b1;
            err_q   <= digit_bad;
            // A bad operand takes a single dummy shift of an all-zero register, giving two-cycle latency.
            if (digit_bad) begin
              sr_q  <= '0;
              ctr_q <= CW'(1);
            end else begin
              sr_q  <= {bus.i_bcd, {OUTPUT_WIDTH{1'b0}}};
              ctr_q <= CW'(OUTPUT_WIDTH);
            end
          end
        end
        s_SHIFT: begin
          sr_q  <= sr_d;
          ctr_q <= ctr_q - 1'b1;
          if (ctr_q == CW'(1)) state_q <= s_DONE;
        end
        s_DONE: begin
          binary_q   <= err_q ? '0 : sr_q[OUTPUT_WIDTH-1:0];
          error_q    <= err_q;
          overflow_q <= (sr_q[SW-1:OUTPUT_WIDTH] != '0) && !err_q;
          dv_q       <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= s_IDLE;
        end
        default: state_q <= s_IDLE;
      endcase
    end
  end

  assign bus.o_binary   = binary_q;
  assign bus.o_dv       = dv_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_error    = error_q;
  assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed checks of bcd_to_binary: a 4-digit/16-bit instance and a 3-digit/8-bit instance.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_bcd_to_binary;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bcd_to_binary_if #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(16)) bus_a ();
  bcd_to_binary_if #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8))  bus_b ();

  bcd_to_binary #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );
  bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one conversion and waits (bounded) for o_dv; returns as soon as o_dv is seen,
  // so a following call starts in the same cycle o_dv is high.
  task automatic conv(input string tag, input bit use_b, input logic [15:0] bcd,
                      input logic [15:0] exp_bin, input logic exp_err, input logic exp_ovf,
                      input int exp_lat);
    int n;
    logic dv;
    if (use_b) begin bus_b.i_bcd = bcd[11:0]; bus_b.i_start = 1'b1; end
    else       begin bus_a.i_bcd = bcd;       bus_a.i_start = 1'b1; end
    tick();
    bus_a.i_start = 1'b0;
    bus_b.i_start = 1'b0;
    n = 0;
    dv = use_b ? bus_b.o_dv : bus_a.o_dv;
    while (!dv && n < 40) begin
      tick();
      n++;
      dv = use_b ? bus_b.o_dv : bus_a.o_dv;
    end
    check({tag, "_lat"}, n, exp_lat);
    if (use_b) begin
      check({tag, "_bin"}, {24'd0, bus_b.o_binary}, {24'd0, exp_bin[7:0]});
      check({tag, "_err"}, bus_b.o_error, exp_err);
      check({tag, "_ovf"}, bus_b.o_overflow, exp_ovf);
    end else begin
      check({tag, "_bin"}, bus_a.o_binary, exp_bin);
      check({tag, "_err"}, bus_a.o_error, exp_err);
      check({tag, "_ovf"}, bus_a.o_overflow, exp_ovf);
    end
  endtask

  initial begin
    int n_busy, n_dv;
    logic [15:0] cap_bin;
    bus_a.i_start = 1'b0; bus_a.i_bcd = '0;
    bus_b.i_start = 1'b0; bus_b.i_bcd = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;

    check("rst_bin", bus_a.o_binary, 16'h0);
    check("rst_dv", bus_a.o_dv, 1'b0);
    check("rst_busy", bus_a.o_busy, 1'b0);
    check("rst_err", bus_a.o_error, 1'b0);
    check("rst_ovf", bus_a.o_overflow, 1'b0);
    check("rst_b_busy", bus_b.o_busy, 1'b0);

    conv("t1_0000", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 17);
    conv("t2_1234", 1'b0, 16'h1234, 16'h04D2, 1'b0, 1'b0, 17);
    conv("t2_9999", 1'b0, 16'h9999, 16'h270F, 1'b0, 1'b0, 17);
    conv("t3_12A4", 1'b0, 16'h12A4, 16'h0000, 1'b1, 1'b0, 2);
    conv("t3_0042", 1'b0, 16'h0042, 16'h002A, 1'b0, 1'b0, 17);

    // Start requests while busy must be ignored.
    bus_a.i_bcd = 16'h0001; bus_a.i_start = 1'b1;
    tick();
    n_busy = 0; n_dv = 0; cap_bin = '0;
    for (int c = 0; c < 25; c++) begin
      if (bus_a.o_busy) n_busy++;
      if (bus_a.o_dv) begin n_dv++; cap_bin = bus_a.o_binary; end
      bus_a.i_start = (c >= 3 && c <= 10);
      bus_a.i_bcd   = (c >= 3 && c <= 10) ? 16'h9999 : 16'h0001;
      tick();
    end
    bus_a.i_start = 1'b0;
    check("t4_busy_cycles", n_busy, 17);
    check("t4_dv_count", n_dv, 1);
    check("t4_bin", cap_bin, 16'h0001);

    // Reset in the middle of a conversion aborts it without o_dv.
    bus_a.i_bcd = 16'h5555; bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    repeat (4) tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    n_dv = 0; n_busy = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus_a.o_dv) n_dv++;
      if (bus_a.o_busy) n_busy++;
      tick();
    end
    check("t5_dv_count", n_dv, 0);
    check("t5_busy_cycles", n_busy, 0);
    check("t5_bin", bus_a.o_binary, 16'h0);
    check("t5_err", bus_a.o_error, 1'b0);
    check("t5_ovf", bus_a.o_overflow, 1'b0);
    conv("t5_0007", 1'b0, 16'h0007, 16'h0007, 1'b0, 1'b0, 17);

    conv("t6_255", 1'b1, 16'h0255, 16'h00FF, 1'b0, 1'b0, 9);
    conv("t6_256", 1'b1, 16'h0256, 16'h0000, 1'b0, 1'b1, 9);
    conv("t6_999", 1'b1, 16'h0999, 16'h00E7, 1'b0, 1'b1, 9);
    conv("t6_0F0", 1'b1, 16'h00F0, 16'h0000, 1'b1, 1'b0, 2);
    conv("t6_100", 1'b1, 16'h0100, 16'h0064, 1'b0, 1'b0, 9);

    tick();
    check("end_dv_low", bus_b.o_dv, 1'b0);
    check("hold_err", bus_b.o_error, 1'b0);
    check("hold_bin", {24'd0, bus_b.o_binary}, 32'h64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
